// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// The queue entry pairs each fetched instruction with the PC it was fetched from.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fq_entry_t;

endpackage

// File: rtl/ins_fifo.sv
// DEPTH-entry synchronous show-ahead FIFO of {pc, ins} entries with a flush.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module ins_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_entry,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  fq_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only read after it was written,
  // and leaving it unreset lets it map onto plain flops/LUTRAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: one outstanding fetch to a variable-latency memory,
// responses buffered with their PC; a redirect flushes and restarts fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rstd,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_rvalid,
  input  logic [XLEN-1:0] im_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            pending;
  logic            discard;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            push;
  fq_entry_t       head;

  // A slot is reserved for the in-flight response; a same-cycle pop is not credited.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
  assign im_req    = rstd && !redirect && (!pending || im_rvalid)
                     && (occupancy < (CW+1)'(DEPTH));
  assign im_addr   = fetch_pc;

  assign push      = im_rvalid && !discard && !redirect;
  assign out_valid = (count != '0);
  assign out_ins   = head.ins;
  assign out_pc    = head.pc;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
      discard  <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      // A request still in flight must have its response dropped when it lands.
      pending  <= pending && !im_rvalid;
      discard  <= pending && !im_rvalid;
    end else begin
      if (im_rvalid) discard <= 1'b0;
      if (im_req) begin
        pending  <= 1'b1;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd1;
      end else if (im_rvalid) begin
        pending  <= 1'b0;
      end
    end
  end

  ins_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstd       (rstd),
    .flush      (redirect),
    .push       (push),
    .push_entry ('{pc: req_pc, ins: im_rdata}),
    .pop        (out_ready),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic,
// compared against a queue-based reference model and a latency-modelled memory.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstd;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  ent_t        mq[$];
  bit          m_pend;
  bit          m_disc;
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;

  // Memory model: at most one request in flight, response after lat cycles
  bit          mb;
  int          mcnt;
  logic [31:0] maddr;
  int          lat_mode;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rstd        (rstd),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .out_valid   (out_valid),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0;
    m_disc = 0;
    m_fpc  = 32'h0;
    m_rpc  = 32'h0;
    mb     = 0;
    mcnt   = 0;
    maddr  = 32'h0;
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait for posedge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          rv;
    bit          exp_req;
    logic [31:0] rd;
    @(negedge clk);
    rv = mb && (mcnt == 0);
    rd = memfn(maddr);
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = rdy;
    im_rvalid   = rv;
    im_rdata    = rv ? rd : $urandom;
    #1;
    exp_req = !redir && (!m_pend || rv) && ((mq.size() + int'(m_pend)) < DEPTH);
    check1("im_req", im_req, exp_req);
    if (exp_req) check32("im_addr", im_addr, m_fpc);
    check1("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check32("out_pc", out_pc, mq[0].pc);
      check32("out_ins", out_ins, mq[0].ins);
    end
    if (redir) begin
      mq.delete();
      m_disc = m_pend && !rv;
      m_pend = m_pend && !rv;
      m_fpc  = rpc;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (rv) begin
        if (m_disc) m_disc = 0;
        else mq.push_back('{pc: m_rpc, ins: rd});
      end
      if (exp_req) begin
        m_pend = 1;
        m_rpc  = m_fpc;
        m_fpc  = m_fpc + 32'd1;
      end else if (rv) begin
        m_pend = 0;
      end
    end
    if (rv) mb = 0;
    if (im_req === 1'b1) begin
      mb    = 1;
      maddr = im_addr;
      mcnt  = (lat_mode == 0) ? int'($urandom_range(0, 2)) : lat_mode - 1;
    end else if (mb) begin
      mcnt--;
    end
    @(posedge clk);
  endtask

  initial begin
    rstd        = 1'b0;
    im_rvalid   = 1'b0;
    im_rdata    = 32'h0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat_mode    = 1;
    model_reset();
    #1;
    check1("reset_im_req", im_req, 1'b0);
    check1("reset_out_valid", out_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rstd = 1'b1;

    // Streaming at latency 1
    for (int i = 0; i < 10; i++) step(0, 32'h0, 1);

    // Stall until full, then drain
    for (int i = 0; i < 8; i++) step(0, 32'h0, 0);
    check32("full_occupancy", 32'(mq.size()), 32'd4);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 1);

    // Redirect while a latency-3 fetch is in flight
    lat_mode = 3;
    for (int i = 0; i < 20; i++) begin
      if (m_pend && mb && mcnt > 0) begin
        step(1, 32'h20, 1);
        break;
      end
      step(0, 32'h0, 1);
    end
    for (int i = 0; i < 12; i++) step(0, 32'h0, 1);

    // Redirect coinciding with a response and a pop
    lat_mode = 1;
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1);
    step(1, 32'h40, 1);
    for (int i = 0; i < 6; i++) step(0, 32'h0, 1);

    // Fill then simultaneous push/pop
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 1);

    // PC wrap-around
    step(1, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 1);

    // Asynchronous reset between edges
    #2 rstd = 1'b0;
    im_rvalid = 1'b0;
    redirect  = 1'b0;
    #1;
    check1("midreset_im_req", im_req, 1'b0);
    check1("midreset_out_valid", out_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rstd = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 32'h0, 1);

    // Random traffic
    lat_mode = 0;
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
